cap_sensor_array: RTL and testbench

Charge-time measurement front end for the nine-pad capacitive touch array of the whack-a-mole board. A single shared drive pin charges every pad through its resistor. The block counts clock cycles until each pad's sense input reads high, then discharges all pads and repeats. It publishes one 32-bit charge-time reading per pad to the processor and to the random-seed logic; a larger count means the pad is touched.

---
 rtl/cap_sensor_array.sv | 120 ++++++++++++
 tb/tb_cap_sensor_array.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cap_sensor_array.sv
// Charge-time front end for the capacitive pad array: discharge all pads, charge them
// through the shared drive, time each pad's rise, and publish one reading per pad.
module cap_sensor_array #(
  parameter int N_SENSORS        = 9,
  parameter int W                = 32,
  parameter int MAX_COUNT        = 20000,
  parameter int DISCHARGE_CYCLES = 1000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_SENSORS-1:0]   capacitive_sensors_in,
  output logic                   capacitive_sensors_out,
  output logic [N_SENSORS*W-1:0] capacitive_sensor_readings
);

  localparam int PW = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(DISCHARGE_CYCLES - 1);
  localparam logic [W-1:0]  T_LAST     = W'(MAX_COUNT - 1);
  localparam logic [W-1:0]  T_TIMEOUT  = W'(MAX_COUNT);

  typedef enum logic [1:0] {
    DISCHARGE = 2'd0,
    CHARGE    = 2'd1,
    LATCH     = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [N_SENSORS-1:0]   sync1_q, sync1_d;
  logic [N_SENSORS-1:0]   sync2_q, sync2_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [W-1:0]           t_q, t_d;
  logic [N_SENSORS-1:0]   done_q, done_d;
  logic [N_SENSORS*W-1:0] pending_q, pending_d;
  logic [N_SENSORS*W-1:0] readings_q, readings_d;
  logic                   drive_q, drive_d;
  logic [N_SENSORS-1:0]   done_now;

  assign capacitive_sensors_out     = drive_q;
  assign capacitive_sensor_readings = readings_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= DISCHARGE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      phase_q    <= '0;
      t_q        <= '0;
      done_q     <= '0;
      pending_q  <= '0;
      readings_q <= '0;
      drive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      phase_q    <= phase_d;
      t_q        <= t_d;
      done_q     <= done_d;
      pending_q  <= pending_d;
      readings_q <= readings_d;
      drive_q    <= drive_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sync1_d    = capacitive_sensors_in;
    sync2_d    = sync1_q;
    phase_d    = phase_q;
    t_d        = t_q;
    done_d     = done_q;
    pending_d  = pending_q;
    readings_d = readings_q;
    // Includes pads completing this very cycle, so the exit test sees them too.
    done_now   = done_q | sync2_q;

    case (state_q)
      DISCHARGE: begin
        if (phase_q == PHASE_LAST) begin
          state_d = CHARGE;
          phase_d = '0;
          t_d     = '0;
          done_d  = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      CHARGE: begin
        for (int k = 0; k < N_SENSORS; k++) begin
          if (sync2_q[k] && !done_q[k]) begin
            pending_d[k*W +: W] = t_q;
          end else begin
            pending_d[k*W +: W] = pending_q[k*W +: W];
          end
        end
        done_d = done_now;
        // Stopping at T_LAST keeps t below MAX_COUNT, so it can never wrap.
        if ((&done_now) || (t_q == T_LAST)) begin
          state_d = LATCH;
        end else begin
          t_d = t_q + W'(1);
        end
      end
      LATCH: begin
        for (int k = 0; k < N_SENSORS; k++) begin
          readings_d[k*W +: W] = done_q[k] ? pending_q[k*W +: W] : T_TIMEOUT;
        end
        state_d = DISCHARGE;
        phase_d = '0;
      end
      default: begin
        state_d = DISCHARGE;
        phase_d = '0;
      end
    endcase

    drive_d = (state_d != DISCHARGE);
  end

endmodule

// File: tb/tb_cap_sensor_array.sv
// Directed bench for cap_sensor_array with MAX_COUNT=50, DISCHARGE_CYCLES=10.
module tb_cap_sensor_array;

  localparam int N  = 9;
  localparam int W  = 32;
  localparam int MC = 50;
  localparam int DC = 10;

  logic           clock;
  logic           reset;
  logic [N-1:0]   sens;
  logic           drive;
  logic [N*W-1:0] readings;

  int n_tests;
  int n_fail;
  int n_hi;
  int n_lo;
  int c;

  cap_sensor_array #(
    .N_SENSORS(N), .W(W), .MAX_COUNT(MC), .DISCHARGE_CYCLES(DC)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .capacitive_sensors_in     (sens),
    .capacitive_sensors_out    (drive),
    .capacitive_sensor_readings(readings)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rd(input int k);
    return readings[k*W +: W];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!drive && n < 200);
  endtask

  task automatic count_high(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (drive && n < 200);
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    reset = 1'b0;
    sens  = v;
    repeat (3) step();
    reset = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    sens    = '0;

    // Reset state, release timing, all-timeout scan
    repeat (3) step();
    check_eq("rst_drive", {63'd0, drive}, 64'd0);
    check_eq("rst_readings_zero", {63'd0, (readings === '0)}, 64'd1);
    reset = 1'b1;
    wait_rise(n_lo);
    check_eq("release_to_drive", n_lo, 64'd10);
    count_high(n_hi);
    check_eq("timeout_high_cycles", n_hi, 64'd51);
    check_eq("timeout_rd0", rd(0), 64'd50);
    check_eq("timeout_rd8", rd(8), 64'd50);
    wait_rise(n_lo);
    check_eq("timeout_period", n_hi + n_lo, 64'd61);

    // Mid-CHARGE reset at t=20
    repeat (20) step();
    reset = 1'b0;
    #1;
    check_eq("midrst_drive", {63'd0, drive}, 64'd0);
    check_eq("midrst_readings_zero", {63'd0, (readings === '0)}, 64'd1);
    step();
    step();
    reset = 1'b1;
    wait_rise(n_lo);
    check_eq("midrst_discharge", n_lo, 64'd10);
    count_high(n_hi);
    check_eq("midrst_high_cycles", n_hi, 64'd51);
    check_eq("midrst_rd4", rd(4), 64'd50);

    // All pads tied high
    do_reset('1);
    wait_rise(n_lo);
    check_eq("allhi_release", n_lo, 64'd10);
    count_high(n_hi);
    check_eq("allhi_high_cycles", n_hi, 64'd2);
    check_eq("allhi_readings_zero", {63'd0, (readings === '0)}, 64'd1);
    wait_rise(n_lo);
    check_eq("allhi_period", n_hi + n_lo, 64'd12);
    count_high(n_hi);
    wait_rise(n_lo);
    check_eq("allhi_period2", n_hi + n_lo, 64'd12);

    // Staggered rise: pad k high at CHARGE cycle 3k
    do_reset('0);
    wait_rise(n_lo);
    c = 0;
    while (drive && c < 200) begin
      for (int k = 0; k < N; k++) begin
        if (c == 3 * k) sens[k] = 1'b1;
      end
      step();
      c++;
    end
    check_eq("stagger_high_cycles", c, 64'd28);
    for (int k = 0; k < N; k++) begin
      check_eq($sformatf("stagger_rd%0d", k), rd(k), 3 * k + 2);
    end

    // Glitch on pad 0, others high
    do_reset(9'b111111110);
    wait_rise(n_lo);
    c = 0;
    while (drive && c < 200) begin
      if (c == 5) sens[0] = 1'b1;
      if (c == 8) sens[0] = 1'b0;
      step();
      c++;
    end
    check_eq("glitch_high_cycles", c, 64'd9);
    check_eq("glitch_rd0", rd(0), 64'd7);
    check_eq("glitch_rd1", rd(1), 64'd0);

    // Last pad completes exactly at t = MAX_COUNT-1
    do_reset(9'b011111111);
    wait_rise(n_lo);
    c = 0;
    while (drive && c < 200) begin
      if (c == 47) sens[8] = 1'b1;
      step();
      c++;
    end
    check_eq("edge_high_cycles", c, 64'd51);
    check_eq("edge_rd8", rd(8), 64'd49);
    check_eq("edge_rd0", rd(0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
